// File: rtl/vscale_xvec_lsu.sv
// ---------------------------------------------------------------------------
// vscale_xvec_lsu
//
// Vector load/store sequencer for the xvec extension. A load gathers up to
// VEC_LEN words from the 32-bit data memory into one wide packed vector
// (element i at bits [i*XPR_LEN +: XPR_LEN]). A store scatters a wide packed
// vector back to memory, one word per request beat. One command is in flight
// at a time.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_store         1 = store, 0 = load
//   cmd_base          byte address of element 0
//   cmd_stride        signed byte stride between elements
//   cmd_len           element count, values above VEC_LEN are clamped
//   cmd_wdata         store vector, captured when the command is accepted
//   busy              high whenever a command is being processed
//   done              one-cycle completion pulse
//   load_data         gathered vector, held until the next load is accepted
//   mem_req_*         memory request channel (valid/ready handshake)
//   mem_resp_*        in-order read responses, never back-pressured
// ---------------------------------------------------------------------------
module vscale_xvec_lsu #(
    parameter int XPR_LEN = 32,
    parameter int VEC_LEN = 29,
    parameter int CNT_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_store,
    input  logic [XPR_LEN-1:0]         cmd_base,
    input  logic [XPR_LEN-1:0]         cmd_stride,
    input  logic [CNT_W-1:0]           cmd_len,
    input  logic [VEC_LEN*XPR_LEN-1:0] cmd_wdata,
    output logic                       busy,
    output logic                       done,
    output logic [VEC_LEN*XPR_LEN-1:0] load_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [XPR_LEN-1:0]         mem_req_addr,
    output logic                       mem_req_wen,
    output logic [XPR_LEN-1:0]         mem_req_wdata,
    input  logic                       mem_resp_valid,
    input  logic [XPR_LEN-1:0]         mem_resp_rdata
);

    localparam int                 VEC_W   = VEC_LEN * XPR_LEN;
    localparam logic [CNT_W-1:0]   MAX_LEN = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    // Command registers, captured on accept
    logic                 store_q;
    logic [XPR_LEN-1:0]   stride_q;
    logic [CNT_W-1:0]     len_q;
    logic [VEC_W-1:0]     wdata_q;

    // Progress registers
    logic [XPR_LEN-1:0]   addr_q;
    logic [CNT_W-1:0]     icnt;
    logic [CNT_W-1:0]     rcnt;

    logic                 accept;
    logic                 req_fire;
    logic                 last_req;
    logic                 resp_take;
    logic [CNT_W-1:0]     len_clamped;
    logic [CNT_W-1:0]     rcnt_after;
    logic [XPR_LEN-1:0]   wdata_elem;

    assign accept      = cmd_valid && cmd_ready;
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign req_fire    = mem_req_valid && mem_req_ready;
    assign last_req    = req_fire && ((icnt + ONE) == len_q);

    // Responses only count while a load is outstanding; anything else on the
    // response channel is a stray beat and is dropped without side effects.
    assign resp_take  = mem_resp_valid && !store_q &&
                        ((state == ISSUE) || (state == DRAIN)) &&
                        (rcnt < len_q);
    assign rcnt_after = resp_take ? (rcnt + ONE) : rcnt;

    // Select the store element for the current issue slot.
    always_comb begin
        wdata_elem = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (icnt == CNT_W'(i)) begin
                wdata_elem = wdata_q[i*XPR_LEN +: XPR_LEN];
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        // NOTE: every output and the next state get a default first so no
        // path through the case statement can leave a latch behind.
        state_next    = state;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = (len_clamped == '0) ? DONE : ISSUE;
                end
            end

            ISSUE: begin
                // Fields come straight from registers that only move on a
                // handshake, so they hold steady through a stall.
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_wen   = store_q;
                mem_req_wdata = store_q ? wdata_elem : '0;
                if (last_req) begin
                    if (store_q) begin
                        state_next = DONE;
                    end else if (rcnt_after < len_q) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DRAIN: begin
                if (rcnt_after >= len_q) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture and issue-side counters
    always_ff @(posedge clk) begin
        if (reset) begin
            store_q  <= 1'b0;
            stride_q <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            icnt     <= '0;
        end else if (accept) begin
            store_q  <= cmd_store;
            stride_q <= cmd_stride;
            len_q    <= len_clamped;
            wdata_q  <= cmd_wdata;
            addr_q   <= cmd_base;
            icnt     <= '0;
        end else if (req_fire) begin
            icnt   <= icnt + ONE;
            addr_q <= addr_q + stride_q;  // wraps modulo 2^XPR_LEN
        end
    end

    // Response side: gather counter and the assembled vector
    always_ff @(posedge clk) begin
        // NOTE: load_data is a visible output with a defined reset value, so
        // the wide register is cleared on reset rather than left unknown.
        if (reset) begin
            rcnt      <= '0;
            load_data <= '0;
        end else if (accept) begin
            rcnt <= '0;
            // Clearing on a load accept makes unused tail elements read as 0.
            if (!cmd_store) begin
                load_data <= '0;
            end
        end else if (resp_take) begin
            rcnt <= rcnt_after;
            for (int i = 0; i < VEC_LEN; i++) begin
                if (rcnt == CNT_W'(i)) begin
                    load_data[i*XPR_LEN +: XPR_LEN] <= mem_resp_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_vscale_xvec_lsu.sv
module tb_vscale_xvec_lsu;

  localparam int XPR_LEN = 32;
  localparam int VEC_LEN = 29;
  localparam int CNT_W   = 5;
  localparam int VW      = VEC_LEN * XPR_LEN;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_store = 1'b0;
  logic [31:0]        cmd_base = '0;
  logic [31:0]        cmd_stride = '0;
  logic [CNT_W-1:0]   cmd_len = '0;
  logic [VW-1:0]      cmd_wdata = '0;
  logic               busy;
  logic               done;
  logic [VW-1:0]      load_data;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b1;
  logic [31:0]        mem_req_addr;
  logic               mem_req_wen;
  logic [31:0]        mem_req_wdata;
  logic               mem_resp_valid = 1'b0;
  logic [31:0]        mem_resp_rdata = '0;

  vscale_xvec_lsu #(.XPR_LEN(XPR_LEN), .VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .busy(busy), .done(done), .load_data(load_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; } req_t;
  typedef struct { int due; logic [31:0] data; } resp_t;

  req_t  exp_q[$];   // requests the current command must still issue
  req_t  log_q[$];   // requests actually accepted by memory
  resp_t pend_q[$];  // read responses scheduled by the memory model

  logic [VW-1:0] model_vec = '0;  // what load_data must hold
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int drain_cycles = 0;
  int lat = 1;
  bit ready_toggle = 1'b0;
  bit spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model and per-cycle request comparison, all on the falling edge.
  always @(negedge clk) begin
    resp_t r;
    cyc++;
    mem_req_ready = ready_toggle ? ((cyc % 2) == 1) : 1'b1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = pend_q[0].data;
      void'(pend_q.pop_front());
    end else if (spurious) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hDEADBEEF;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
    end
    if (busy && !mem_req_valid && !done) drain_cycles++;
    if (mem_req_valid && !reset) begin
      if (exp_q.size() == 0) begin
        check("extra_req", mem_req_valid, 32'h0);
      end else begin
        check("req_addr", mem_req_addr, exp_q[0].addr);
        check("req_wen", mem_req_wen, exp_q[0].wen);
        check("req_wdata", mem_req_wdata, exp_q[0].wdata);
        if (mem_req_ready) begin
          log_q.push_back('{mem_req_addr, mem_req_wen, mem_req_wdata});
          if (!exp_q[0].wen) begin
            r.due  = cyc + lat;
            r.data = exp_q[0].addr ^ 32'h0000FFFF;
            pend_q.push_back(r);
          end
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end
  end

  task automatic check_vec(input string tag);
    for (int i = 0; i < VEC_LEN; i++) begin
      check($sformatf("%s_elem%0d", tag, i), load_data[i*32 +: 32], model_vec[i*32 +: 32]);
    end
  endtask

  // Issue one command and follow it to completion.
  task automatic run_cmd(input string tag, input bit st, input logic [31:0] base,
                         input logic [31:0] stride, input int len,
                         input logic [VW-1:0] wv, input int exp_lat);
    int n;
    int k;
    bit got;
    logic [31:0] a;
    n = (len > VEC_LEN) ? VEC_LEN : len;
    exp_q.delete();
    log_q.delete();
    hs_count = 0;
    a = base;
    if (!st) model_vec = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a, st, st ? wv[i*32 +: 32] : 32'h0});
      if (!st) model_vec[i*32 +: 32] = a ^ 32'h0000FFFF;
      a = a + stride;
    end
    @(posedge clk); #1;
    check({tag, "_cmd_ready"}, cmd_ready, 32'h1);
    cmd_valid  = 1'b1;
    cmd_store  = st;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_len    = CNT_W'(len);
    cmd_wdata  = wv;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain_cycles = 0;
    check({tag, "_busy"}, busy, 32'h1);
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 32'h1);
    if (got) begin
      if (exp_lat >= 0) check({tag, "_latency"}, k, exp_lat);
      check({tag, "_req_count"}, hs_count, n);
      check({tag, "_req_left"}, exp_q.size(), 32'h0);
      check_vec(tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 32'h0);
      check({tag, "_idle"}, busy, 32'h0);
    end
  endtask

  initial begin
    logic [VW-1:0] wv;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_cmd_ready", cmd_ready, 32'h1);
    check("rst_busy", busy, 32'h0);
    check("rst_done", done, 32'h0);
    check("rst_req_valid", mem_req_valid, 32'h0);
    check("rst_req_wen", mem_req_wen, 32'h0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_req_wdata", mem_req_wdata, 32'h0);
    check_vec("rst");

    // Store A/B/C to 0x100, 0x104, 0x108.
    wv = '0;
    wv[31:0]  = 32'hA;
    wv[63:32] = 32'hB;
    wv[95:64] = 32'hC;
    run_cmd("st3", 1'b1, 32'h100, 32'd4, 3, wv, 4);
    check("st3_log_n", log_q.size(), 32'd3);
    check("st3_a0", log_q[0].addr, 32'h100);
    check("st3_a2", log_q[2].addr, 32'h108);
    check("st3_d1", log_q[1].wdata, 32'hB);
    check("st3_d2", log_q[2].wdata, 32'hC);

    // Load with negative stride, 1-cycle response latency.
    lat = 1;
    run_cmd("ld4", 1'b0, 32'h200, 32'hFFFFFFF8, 4, '0, 6);
    check("ld4_a3", log_q[3].addr, 32'h1E8);
    check("ld4_e0", load_data[31:0], 32'h0000FDFF);
    check("ld4_e3", load_data[127:96], 32'h0000FE17);
    check("ld4_e4", load_data[159:128], 32'h0);

    // Zero-length store with stray responses: no traffic, load_data held.
    spurious = 1'b1;
    run_cmd("st0", 1'b1, 32'h500, 32'd4, 0, '1, 1);
    spurious = 1'b0;
    check("st0_e3", load_data[127:96], 32'h0000FE17);

    // Full-length load, ready toggling, 3-cycle latency: must drain.
    ready_toggle = 1'b1;
    lat = 3;
    run_cmd("ld29", 1'b0, 32'h1000, 32'd4, 29, '0, -1);
    check("ld29_drain", drain_cycles > 0, 32'h1);
    ready_toggle = 1'b0;

    // Over-length load is clamped to 29 elements.
    lat = 1;
    run_cmd("ld31", 1'b0, 32'h2000, 32'd8, 31, '0, 31);

    // Address wrap on a store, with stray responses present.
    wv = '0;
    for (int i = 0; i < 4; i++) wv[i*32 +: 32] = 32'h50 + i;
    spurious = 1'b1;
    run_cmd("wrap", 1'b1, 32'hFFFFFFF8, 32'd4, 4, wv, 5);
    spurious = 1'b0;
    check("wrap_a0", log_q[0].addr, 32'hFFFFFFF8);
    check("wrap_a1", log_q[1].addr, 32'hFFFFFFFC);
    check("wrap_a2", log_q[2].addr, 32'h0);
    check("wrap_a3", log_q[3].addr, 32'h4);
    check("wrap_e0", load_data[31:0], 32'h2000 ^ 32'h0000FFFF);

    // Reset in ISSUE after 2 of 5 loads have been accepted.
    lat = 1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back('{32'h400 + 32'(i * 4), 1'b0, 32'h0});
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_store  = 1'b0;
    cmd_base   = 32'h400;
    cmd_stride = 32'd4;
    cmd_len    = 5'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_e0_before", load_data[31:0], 32'h0000FBFF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_vec = '0;
    check("rstmid_busy", busy, 32'h0);
    check("rstmid_ready", cmd_ready, 32'h1);
    check("rstmid_valid", mem_req_valid, 32'h0);
    check("rstmid_done", done, 32'h0);
    check_vec("rstmid");
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1 spurious = 1'b0;
    check("rstmid_late_busy", busy, 32'h0);
    check_vec("rstmid_late");

    // Normal load after reset, 2-cycle latency.
    lat = 2;
    run_cmd("post", 1'b0, 32'h300, 32'd4, 5, '0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_xvec_lsu.md
Name: vscale_xvec_lsu

Overview:
- Vector load/store sequencer for the xvec extension.
- Gathers up to VEC_LEN words from 32-bit data memory into one wide packed vector, which becomes an operand of the vector ALU.
- Scatters a wide packed vector, such as an ALU result, back to memory one word per beat.
- Sits between the xvec execute stage and the data-memory port; one command is in flight at a time.

Parameters:
- XPR_LEN, 32, element and memory word width in bits.
- VEC_LEN, 29, maximum elements per vector; element i occupies bits [i*XPR_LEN +: XPR_LEN].
- CNT_W, 5, counter width; must satisfy 2**CNT_W > VEC_LEN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_store  in  1  1 = store, 0 = load.
- cmd_base  in  XPR_LEN  byte address of element 0.
- cmd_stride  in  XPR_LEN  signed byte stride between elements.
- cmd_len  in  CNT_W  element count; valid range 0..VEC_LEN.
- cmd_wdata  in  VEC_LEN*XPR_LEN  store vector, sampled at command accept.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  VEC_LEN*XPR_LEN  gathered vector; holds its value until the next load is accepted.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  XPR_LEN  request byte address.
- mem_req_wen  out  1  1 = write.
- mem_req_wdata  out  XPR_LEN  write data.
- mem_resp_valid  in  1  read data valid; responses arrive in order.
- mem_resp_rdata  in  XPR_LEN  read data.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; busy=0; done=0; mem_req_valid=0; mem_req_wen=0; mem_req_addr=0; mem_req_wdata=0; load_data=0; all counters=0.
- Command accept: a command is accepted when cmd_valid && cmd_ready. On accept, latch store flag, stride, len and wdata; set the address register to cmd_base; clear issue count (icnt) and response count (rcnt).
- On a load accept, load_data is cleared to 0. Elements at index >= len therefore read as 0 at completion.
- cmd_len > VEC_LEN is clamped to VEC_LEN.
- States:
  - IDLE: on accept with len=0, go to DONE with no memory traffic. On any other accept, go to ISSUE.
  - ISSUE: mem_req_valid=1; mem_req_addr=addr register; mem_req_wen=store flag; mem_req_wdata=element icnt of the latched wdata (0 for loads).
    - On mem_req_ready: icnt++, and addr += stride (modulo 2^XPR_LEN, wraps silently).
    - Request fields must stay stable while valid && !ready.
    - When the last request is accepted (icnt reaches len): a store goes to DONE; a load goes to DRAIN if rcnt+resp_this_cycle < len, otherwise to DONE.
  - DRAIN (loads only): mem_req_valid=0. Wait until rcnt reaches len, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. load_data is final when done is high.
- Responses (loads): mem_resp_valid writes mem_resp_rdata into element rcnt, then rcnt++.
  - Accepted in both ISSUE and DRAIN, including in the same cycle as a request handshake.
  - A response may arrive in the cycle after its request was accepted.
  - The block never applies backpressure to responses.
- Spurious responses: mem_resp_valid while IDLE, DONE, or during a store is ignored and causes no state change.
- Stores produce no response and complete on acceptance of the last request.
- Pipelining: multiple load requests may be outstanding; one request can issue per cycle when mem_req_ready stays high.
- Latency examples:
  - Store, len=N, ready always 1: done is high N+1 cycles after accept.
  - Load, len=N, ready always 1, response latency 1: done is high N+2 cycles after accept.
- Reset mid-operation: all state returns to reset values next cycle; mem_req_valid drops immediately; responses that arrive later are ignored.
- cmd_valid while busy is not accepted; cmd_ready=0.

Test Plan:
- Store, base=0x100, stride=4, len=3, wdata elements 0..2 = 0xA, 0xB, 0xC, ready=1 -> writes to 0x100/0x104/0x108 with data A/B/C on consecutive cycles; done 4 cycles after accept.
- Load, base=0x200, stride=-8, len=4, memory returns addr^0xFFFF with 1-cycle latency -> addresses 0x200/0x1F8/0x1F0/0x1E8; load_data elements 0..3 match; elements 4..28 = 0; done pulses once.
- Load, len=29, mem_req_ready toggling 1,0,1,0 and response latency 3 -> address and wen stable during stalls; all 29 elements correct; DRAIN entered; no extra requests issued.
- len=0 store, then len=31 load -> first: done 1 cycle after accept, zero mem_req_valid cycles; second: clamped to 29 requests.
- Base=0xFFFFFFF8, stride=4, len=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset asserted in ISSUE after 2 of 5 loads, with a response arriving after reset -> next cycle: IDLE, mem_req_valid=0, load_data=0; late response ignored; next command runs normally.
